// File: rtl/y86_run_ctrl_if.sv
// Run-control bundle: program-load handshake, imem write port, run/step/stop
// controls, write-back status taps and the pipeline gating/status outputs.
interface y86_run_ctrl_if #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
);
    logic             load_req;
    logic [LEN_W-1:0] load_len;
    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_ready;
    logic             run;
    logic             step;
    logic             stop;
    logic [1:0]       W_stat;
    logic [3:0]       W_icode;
    logic             imem_wEn;
    logic [63:0]      imem_addr;
    logic [7:0]       imem_wdata;
    logic             pipe_en;
    logic             pipe_rst;
    logic [2:0]       state;
    logic             halted;
    logic [1:0]       final_stat;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport slave (
        input  load_req, load_len, load_valid, load_data, run, step, stop, W_stat, W_icode,
        output load_ready, imem_wEn, imem_addr, imem_wdata, pipe_en, pipe_rst, state,
               halted, final_stat, cycle_cnt, retire_cnt
    );

    modport master (
        output load_req, load_len, load_valid, load_data, run, step, stop, W_stat, W_icode,
        input  load_ready, imem_wEn, imem_addr, imem_wdata, pipe_en, pipe_rst, state,
               halted, final_stat, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/y86_run_ctrl.sv
// Y86-64 run control: loads imem at 1 byte/cycle, flushes, then gates pipe_en (free-run/step).
// Gating outputs decode from state the same cycle; loader backpressures via load_ready outside LOAD.
module y86_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FLUSH_CYC = 5,
    parameter int LEN_W     = 16
) (
    input logic         clk,
    input logic         rst,
    y86_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        READY = 3'd3,
        RUN   = 3'd4,
        STEP  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    state_t           curState;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] lenReg;
    logic [FC_W-1:0]  flushCnt;
    logic [1:0]       finalStat;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] retireCnt;

    logic pipeEn;
    logic byteAcc;
    logic haltNow;
    logic retireNow;

    assign pipeEn    = (curState == RUN) || (curState == STEP);
    assign byteAcc   = (curState == LOAD) && bus.load_valid;
    assign haltNow   = (bus.W_stat != 2'd0);
    // HLT still retires its instruction; ADR/INS faults do not.
    assign retireNow = (bus.W_icode != 4'd1) && !bus.W_stat[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState  <= IDLE;
            idx       <= '0;
            lenReg    <= '0;
            flushCnt  <= '0;
            finalStat <= 2'd0;
            cycleCnt  <= '0;
            retireCnt <= '0;
        end else begin
            if (pipeEn) begin
                if (cycleCnt != '1)
                    cycleCnt <= cycleCnt + CNT_W'(1);
                if (retireNow && (retireCnt != '1))
                    retireCnt <= retireCnt + CNT_W'(1);
            end

            case (curState)
                IDLE, READY, DONE: begin
                    if ((curState == READY) && bus.run) begin
                        curState <= RUN;
                    end else if ((curState == READY) && bus.step) begin
                        curState <= STEP;
                    end else if (bus.load_req) begin
                        lenReg <= bus.load_len;
                        idx    <= '0;
                        if (bus.load_len != '0) begin
                            curState <= LOAD;
                        end else begin
                            curState  <= FLUSH;
                            flushCnt  <= '0;
                            finalStat <= 2'd0;
                            cycleCnt  <= '0;
                            retireCnt <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (bus.load_valid) begin
                        if (idx == lenReg - LEN_W'(1)) begin
                            curState  <= FLUSH;
                            idx       <= '0;
                            flushCnt  <= '0;
                            finalStat <= 2'd0;
                            cycleCnt  <= '0;
                            retireCnt <= '0;
                        end else begin
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flushCnt == FC_W'(FLUSH_CYC - 1)) begin
                        curState <= READY;
                        flushCnt <= '0;
                    end else begin
                        flushCnt <= flushCnt + FC_W'(1);
                    end
                end
                RUN: begin
                    if (haltNow) begin
                        curState  <= DONE;
                        finalStat <= bus.W_stat;
                    end else if (bus.stop) begin
                        curState <= READY;
                    end
                end
                STEP: begin
                    if (haltNow) begin
                        curState  <= DONE;
                        finalStat <= bus.W_stat;
                    end else begin
                        curState <= READY;
                    end
                end
                default: curState <= IDLE;
            endcase
        end
    end

    assign bus.state      = curState;
    assign bus.load_ready = (curState == LOAD);
    assign bus.imem_wEn   = byteAcc;
    assign bus.imem_addr  = byteAcc ? {{(64 - LEN_W){1'b0}}, idx} : 64'd0;
    assign bus.imem_wdata = byteAcc ? bus.load_data : 8'd0;
    assign bus.pipe_en    = pipeEn;
    assign bus.pipe_rst   = (curState == IDLE) || (curState == FLUSH);
    assign bus.halted     = (curState == DONE);
    assign bus.final_stat = finalStat;
    assign bus.cycle_cnt  = cycleCnt;
    assign bus.retire_cnt = retireCnt;
endmodule

// File: tb/tb_y86_run_ctrl.sv
// Scoreboarded bench for y86_run_ctrl: stimulus tasks queue expected state
// transitions and imem writes; negedge monitors pop and compare them.
module tb_y86_run_ctrl;
    localparam int CNT_W     = 4;
    localparam int FLUSH_CYC = 5;
    localparam int LEN_W     = 16;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_run_ctrl_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    y86_run_ctrl #(.CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int dwell;   // cycles spent in the state being left, -1 = don't care
        int st;
        int cyc;
        int ret;
        int fst;
    } trans_t;

    typedef struct {
        longint addr;
        int     data;
    } wr_t;

    trans_t     expT[$];
    wr_t        expW[$];
    logic [7:0] ldData[$];

    int errors = 0;
    int checks = 0;
    int mCyc = 0, mRet = 0, mFst = 0, mSt = 0;
    bit monOn = 1'b0;
    int prevSt = 0;
    int dwellCnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every imem write must match the next queued byte.
    always @(negedge clk) begin
        wr_t w;
        if (monOn && bus.imem_wEn) begin
            chk("wr_load_ready", bus.load_ready, 1);
            if (expW.size() == 0) begin
                chk("unexpected_write_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = expW.pop_front();
                chk("wr_addr", bus.imem_addr, w.addr);
                chk("wr_data", bus.imem_wdata, w.data);
            end
        end
    end

    // State monitor: every state change must match the next queued transition.
    always @(negedge clk) begin
        trans_t t;
        if (monOn) begin
            if (int'(bus.state) != prevSt) begin
                if (expT.size() == 0) begin
                    chk("unexpected_state", bus.state, prevSt);
                end else begin
                    t = expT.pop_front();
                    if (t.dwell >= 0) chk("dwell", dwellCnt, t.dwell);
                    chk("state", bus.state, t.st);
                    chk("cycle_cnt", bus.cycle_cnt, t.cyc);
                    chk("retire_cnt", bus.retire_cnt, t.ret);
                    chk("final_stat", bus.final_stat, t.fst);
                    chk("pipe_en", bus.pipe_en, (t.st == 4 || t.st == 5) ? 1 : 0);
                    chk("pipe_rst", bus.pipe_rst, (t.st == 0 || t.st == 2) ? 1 : 0);
                    chk("halted", bus.halted, (t.st == 6) ? 1 : 0);
                    chk("load_ready", bus.load_ready, (t.st == 1) ? 1 : 0);
                end
                prevSt   = int'(bus.state);
                dwellCnt = 1;
            end else begin
                dwellCnt++;
            end
        end
    end

    task automatic chkReset(input string tag);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_pipe_rst"}, bus.pipe_rst, 1);
        chk({tag, "_pipe_en"}, bus.pipe_en, 0);
        chk({tag, "_load_ready"}, bus.load_ready, 0);
        chk({tag, "_imem_wEn"}, bus.imem_wEn, 0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_halted"}, bus.halted, 0);
        chk({tag, "_final_stat"}, bus.final_stat, 0);
        chk({tag, "_cycle_cnt"}, bus.cycle_cnt, 0);
        chk({tag, "_retire_cnt"}, bus.retire_cnt, 0);
    endtask

    // gapMode: 0 = back-to-back, 1 = one idle cycle between bytes, 2 = random idles
    task automatic doLoad(input int gapMode);
        int len;
        int gaps[$];
        int dw;
        len = ldData.size();
        dw  = 0;
        for (int i = 0; i < len; i++) begin
            int g;
            g = (i == 0) ? 0 : (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 2)) : 0;
            gaps.push_back(g);
            dw += g + 1;
            expW.push_back(wr_t'{longint'(i), int'(ldData[i])});
        end
        if (len != 0) expT.push_back(trans_t'{-1, 1, mCyc, mRet, mFst});
        expT.push_back(trans_t'{(len != 0) ? dw : -1, 2, 0, 0, 0});
        expT.push_back(trans_t'{FLUSH_CYC, 3, 0, 0, 0});
        mCyc = 0; mRet = 0; mFst = 0; mSt = 3;

        bus.load_req   = 1'b1;
        bus.load_len   = LEN_W'(len);
        bus.load_valid = 1'b0;
        tick();
        bus.load_req = 1'b0;
        bus.load_len = LEN_W'($urandom);
        for (int i = 0; i < len; i++) begin
            repeat (gaps[i]) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'($urandom);
                bus.run        = 1'($urandom);
                bus.step       = 1'($urandom);
                bus.stop       = 1'($urandom);
                bus.load_req   = 1'($urandom);
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = ldData[i];
            tick();
        end
        bus.load_valid = 1'b0;
        bus.run = 1'b0; bus.step = 1'b0; bus.stop = 1'b0; bus.load_req = 1'b0;
        repeat (FLUSH_CYC) tick();
    endtask

    task automatic doStep(input int ic, input int st);
        int nc, nr;
        nc = sat(mCyc + 1);
        nr = (ic != 1 && st <= 1) ? sat(mRet + 1) : mRet;
        expT.push_back(trans_t'{-1, 5, mCyc, mRet, mFst});
        expT.push_back(trans_t'{1, (st != 0) ? 6 : 3, nc, nr, (st != 0) ? st : mFst});
        mCyc = nc; mRet = nr;
        if (st != 0) mFst = st;
        mSt = (st != 0) ? 6 : 3;

        bus.step = 1'b1;
        tick();
        bus.step    = 1'b0;
        bus.W_icode = 4'(ic);
        bus.W_stat  = 2'(st);
        tick();
        bus.W_icode = 4'd1;
        bus.W_stat  = 2'd0;
    endtask

    // Runs k pipe_en cycles; the last one carries status hs and optionally stop.
    task automatic doRun(input int k, input int hs, input bit stp);
        int ic[$];
        int nc, nr;
        nc = mCyc;
        nr = mRet;
        for (int j = 0; j < k; j++) begin
            int s;
            ic.push_back(($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 11)));
            s  = (j == k - 1) ? hs : 0;
            nc = sat(nc + 1);
            if (ic[j] != 1 && s <= 1) nr = sat(nr + 1);
        end
        expT.push_back(trans_t'{-1, 4, mCyc, mRet, mFst});
        expT.push_back(trans_t'{k, (hs != 0) ? 6 : 3, nc, nr, (hs != 0) ? hs : mFst});
        mCyc = nc; mRet = nr;
        if (hs != 0) mFst = hs;
        mSt = (hs != 0) ? 6 : 3;

        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        for (int j = 0; j < k; j++) begin
            bus.W_icode  = 4'(ic[j]);
            bus.W_stat   = (j == k - 1) ? 2'(hs) : 2'd0;
            bus.stop     = (j == k - 1) && stp;
            bus.load_req = (j == 1) && (k > 3);
            bus.load_len = LEN_W'(1);
            tick();
        end
        bus.W_icode = 4'd1; bus.W_stat = 2'd0; bus.stop = 1'b0; bus.load_req = 1'b0;
    endtask

    task automatic randData(input int n);
        ldData.delete();
        for (int i = 0; i < n; i++) ldData.push_back(8'($urandom));
    endtask

    initial begin
        bus.load_req = 1'b0; bus.load_len = '0; bus.load_valid = 1'b0; bus.load_data = 8'd0;
        bus.run = 1'b0; bus.step = 1'b0; bus.stop = 1'b0;
        bus.W_stat = 2'd0; bus.W_icode = 4'd1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        prevSt = 0; dwellCnt = 0; monOn = 1'b1;

        // Three-byte program, back-to-back
        ldData.delete();
        ldData.push_back(8'h30); ldData.push_back(8'hF2); ldData.push_back(8'h10);
        doLoad(0);

        // Three single steps: one real instruction, two bubbles
        doStep(6, 0);
        doStep(1, 0);
        doStep(1, 0);

        // Four bytes with valid toggling, then run until HLT on cycle 10
        randData(4);
        doLoad(1);
        doRun(10, 1, 1'b0);

        // run/step are ignored while halted
        bus.run = 1'b1; tick(); bus.run = 1'b0;
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        tick();

        // Reload, pause with stop, then stop coinciding with ADR fault
        randData(6);
        doLoad(2);
        doRun(5, 0, 1'b1);
        doRun(4, 2, 1'b1);

        // Zero-length reload from DONE clears everything; long run saturates counters
        ldData.delete();
        doLoad(0);
        doRun(20, 0, 1'b1);
        doStep(3, 0);
        doRun(6, 3, 1'b0);

        // Reset in the middle of a 5-byte load started from a halted state
        randData(5);
        expT.push_back(trans_t'{-1, 1, mCyc, mRet, mFst});
        expW.push_back(wr_t'{64'd0, int'(ldData[0])});
        expW.push_back(wr_t'{64'd1, int'(ldData[1])});
        expT.push_back(trans_t'{-1, 0, 0, 0, 0});
        bus.load_req = 1'b1; bus.load_len = LEN_W'(5);
        tick();
        bus.load_req = 1'b0;
        bus.load_valid = 1'b1; bus.load_data = ldData[0];
        tick();
        bus.load_data = ldData[1];
        tick();
        bus.load_data = ldData[2];
        #2;
        rst = 1'b1;
        mCyc = 0; mRet = 0; mFst = 0; mSt = 0;
        @(negedge clk);
        chkReset("mid_load_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.load_valid = 1'b0;
        tick();
        randData(1);
        doLoad(0);

        // Randomized mix of loads, steps and runs
        for (int it = 0; it < 10; it++) begin
            if (mSt != 3 || $urandom_range(0, 2) == 0) begin
                randData(int'($urandom_range(0, 7)));
                doLoad(2);
            end
            if ($urandom_range(0, 1) == 0) begin
                doStep(int'($urandom_range(0, 11)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end else begin
                int hs;
                hs = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                doRun(int'($urandom_range(1, 12)), hs, (hs == 0) ? 1'b1 : 1'($urandom));
            end
        end

        repeat (2) tick();
        chk("pending_transitions", expT.size(), 0);
        chk("pending_writes", expW.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
